// File: rtl/itype_wb_checker.sv
// itype_wb_checker
// Retire-side checker for the I-type ALU instruction stream. Each fetched
// I-type instruction is decoded against a shadow register file; the expected
// writeback {rd, result} is queued and compared with the core's writeback
// stream.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   instr_valid, instr           in-order fetched instruction
//   init_we/init_addr/init_data  shadow regfile seeding port
//   wb_valid/wb_addr/wb_data     core register writeback
//   exp_valid/exp_addr/exp_data  expected-writeback FIFO head
//   mismatch                     one-cycle pulse after a failed compare
//   err_sticky                   set on the first mismatch
//   overflow                     an expectation was dropped on a full FIFO
//   unsupported                  non-I-type or illegal-shift instruction seen
//   check_count, mismatch_count  saturating counters
//
// Optional: define ITYPE_CHK_FATAL_EN to report the first mismatch and stop
// the simulation with $fatal.
module itype_wb_checker #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    input  logic             init_we,
    input  logic [4:0]       init_addr,
    input  logic [31:0]      init_data,
    input  logic             wb_valid,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    output logic             exp_valid,
    output logic [4:0]       exp_addr,
    output logic [31:0]      exp_data,
    output logic             mismatch,
    output logic             err_sticky,
    output logic             overflow,
    output logic             unsupported,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] mismatch_count
);

    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [6:0]  OP_IMM = 7'b0010011;

    logic [31:0] rf [32];
    logic [4:0]  q_addr [DEPTH];
    logic [31:0] q_data [DEPTH];
    logic [AW:0] wptr, rptr;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, shamt;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm, src, result;
    logic        legal;

    logic        empty, full, push_req, do_push, drop, wb_chk, pop, miss;
    logic [4:0]  head_addr;
    logic [31:0] head_data;

    // Instruction decode and ALU evaluation against the shadow regfile
    always_comb begin
        opcode = instr[6:0];
        rd     = instr[11:7];
        funct3 = instr[14:12];
        rs1    = instr[19:15];
        shamt  = instr[24:20];
        funct7 = instr[31:25];
        imm    = {{20{instr[31]}}, instr[31:20]};
        src    = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
        legal  = 1'b0;
        result = 32'd0;
        if (opcode == OP_IMM) begin
            case (funct3)
                3'd0: begin legal = 1'b1; result = src + imm; end
                3'd2: begin legal = 1'b1; result = {31'd0, $signed(src) < $signed(imm)}; end
                3'd3: begin legal = 1'b1; result = {31'd0, src < imm}; end
                3'd4: begin legal = 1'b1; result = src ^ imm; end
                3'd6: begin legal = 1'b1; result = src | imm; end
                3'd7: begin legal = 1'b1; result = src & imm; end
                3'd1: begin
                    legal  = (funct7 == 7'd0);
                    result = src << shamt;
                end
                default: begin
                    if (funct7 == 7'd0) begin
                        legal  = 1'b1;
                        result = src >> shamt;
                    end else if (funct7 == 7'b0100000) begin
                        legal  = 1'b1;
                        result = 32'($signed(src) >>> shamt);
                    end
                end
            endcase
        end
    end

    // FIFO status and compare
    always_comb begin
        empty     = (wptr == rptr);
        full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        head_addr = q_addr[rptr[AW-1:0]];
        head_data = q_data[rptr[AW-1:0]];
        push_req  = instr_valid && legal && (rd != 5'd0);
        wb_chk    = wb_valid && (wb_addr != 5'd0);
        pop       = wb_chk && !empty;
        do_push   = push_req && (!full || pop);
        drop      = push_req && full && !pop;
        miss      = wb_chk && (empty || (wb_addr != head_addr) || (wb_data != head_data));
    end

    assign exp_valid = !empty;
    assign exp_addr  = empty ? 5'd0  : head_addr;
    assign exp_data  = empty ? 32'd0 : head_data;

    // Storage without reset: shadow regfile survives reset; instruction
    // result overrides a same-cycle seed of the same register.
    always_ff @(posedge clk) begin
        if (init_we && (init_addr != 5'd0))
            rf[init_addr] <= init_data;
        if (push_req)
            rf[rd] <= result;
        if (do_push) begin
            q_addr[wptr[AW-1:0]] <= rd;
            q_data[wptr[AW-1:0]] <= result;
        end
    end

    // Pointers, flags and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr           <= '0;
            rptr           <= '0;
            mismatch       <= 1'b0;
            err_sticky     <= 1'b0;
            overflow       <= 1'b0;
            unsupported    <= 1'b0;
            check_count    <= '0;
            mismatch_count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + (AW+1)'(1);
            if (pop)
                rptr <= rptr + (AW+1)'(1);
            mismatch <= miss;
            if (miss)
                err_sticky <= 1'b1;
            if (drop)
                overflow <= 1'b1;
            if (instr_valid && !legal)
                unsupported <= 1'b1;
            if (wb_chk && (check_count != '1))
                check_count <= check_count + CNT_W'(1);
            if (miss && (mismatch_count != '1))
                mismatch_count <= mismatch_count + CNT_W'(1);
        end
    end

`ifdef ITYPE_CHK_FATAL_EN
    longint unsigned cycle_cnt;

    // Report and stop on the first mismatch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (miss && !err_sticky) begin
                $display("itype_wb_checker: cycle %0d expected x%0d=%08h observed x%0d=%08h",
                         cycle_cnt, exp_addr, exp_data, wb_addr, wb_data);
                $fatal(1, "itype_wb_checker: writeback mismatch");
            end
        end
    end
`endif

endmodule
